// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - register-file write port arbiter between pipeline writeback and load returns
module wb_port_arbiter #(
    parameter int DATA_W = 16,
    parameter int REG_W  = 3,
    parameter int DEPTH  = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     pipe_valid,
    input  logic                     pipe_jal_en,
    input  logic [REG_W-1:0]         pipe_wr_reg,
    input  logic [DATA_W-1:0]        pipe_alu_out,
    input  logic [DATA_W-1:0]        pipe_pc_next,
    output logic                     pipe_stall,
    input  logic                     ld_valid,
    input  logic [REG_W-1:0]         ld_wr_reg,
    input  logic [DATA_W-1:0]        ld_data,
    output logic                     rf_wr_en,
    output logic [REG_W-1:0]         rf_wr_reg,
    output logic [DATA_W-1:0]        rf_wr_data,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [REG_W-1:0]  q_reg  [DEPTH];
    logic [DATA_W-1:0] q_data [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;

    logic              accept;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] pipe_data;

    // Stall decodes only the registered count so it never depends on this cycle's requests.
    assign pipe_stall = (fifo_count == CNT_W'(DEPTH));
    assign fifo_empty = (fifo_count == '0);
    assign accept     = pipe_valid & ~pipe_stall;
    assign pipe_data  = pipe_jal_en ? pipe_pc_next : pipe_alu_out;

    always_comb begin
        push = 1'b0;
        pop  = 1'b0;
        if (ld_valid) begin
            push = accept;
        end else if (!fifo_empty) begin
            pop  = 1'b1;
            push = accept;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_reg[wr_ptr]  <= pipe_wr_reg;
            q_data[wr_ptr] <= pipe_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_wr_en   <= 1'b0;
            rf_wr_reg  <= '0;
            rf_wr_data <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            rf_wr_en <= 1'b0;
            if (ld_valid) begin
                rf_wr_en   <= 1'b1;
                rf_wr_reg  <= ld_wr_reg;
                rf_wr_data <= ld_data;
            end else if (!fifo_empty) begin
                rf_wr_en   <= 1'b1;
                rf_wr_reg  <= q_reg[rd_ptr];
                rf_wr_data <= q_data[rd_ptr];
            end else if (accept) begin
                rf_wr_en   <= 1'b1;
                rf_wr_reg  <= pipe_wr_reg;
                rf_wr_data <= pipe_data;
            end

            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);

            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && pipe_stall));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) !(pop && fifo_empty));

endmodule
